// File: rtl/mips_mem_pkg.sv
// Shared definitions for the unified I/D memory port arbiter.
//   arb_state_e   : arbiter FSM states (idle, fetch in flight, data access in flight)
//   IF_FETCH_BE   : byte enables driven for every instruction fetch
//   TIMEOUT_RDATA : read data returned to a requester whose access timed out
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IBUSY = 2'd1,
        ST_DBUSY = 2'd2
    } arb_state_e;

    localparam logic [3:0]  IF_FETCH_BE   = 4'hF;
    localparam logic [31:0] TIMEOUT_RDATA = 32'h0;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported unified memory between instruction fetch (IF)
// and load/store (MEM). A granted access is held on the registered memory
// port until i_mem_ready, or until MAX_WAIT cycles pass (then it is aborted
// and the sticky o_err is raised).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_IF_req/addr/flush      fetch request, PC, branch redirect
//   o_IF_rdata/valid/stall   fetched instruction, completion pulse, stall
//   i_MEM_req/we/addr/wdata/be  load/store request
//   o_MEM_rdata/valid/stall  load data, completion pulse, stall
//   o_mem_req/we/addr/wdata/be  registered memory port
//   i_mem_ready, i_mem_rdata memory completion and read data
//   o_err                    sticky timeout flag
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter bit          DATA_PRIORITY = 1'b1,
    parameter int unsigned MAX_WAIT      = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_IF_req,
    input  logic [31:0] i_IF_addr,
    input  logic        i_IF_flush,
    output logic [31:0] o_IF_rdata,
    output logic        o_IF_valid,
    output logic        o_IF_stall,
    input  logic        i_MEM_req,
    input  logic        i_MEM_we,
    input  logic [31:0] i_MEM_addr,
    input  logic [31:0] i_MEM_wdata,
    input  logic [3:0]  i_MEM_be,
    output logic [31:0] o_MEM_rdata,
    output logic        o_MEM_valid,
    output logic        o_MEM_stall,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata,
    output logic        o_err
);

    // Counter value seen in the last busy cycle before an abort; the port is
    // therefore held for exactly MAX_WAIT cycles when ready never arrives.
    localparam logic [3:0] LAST_WAIT = 4'(MAX_WAIT - 1);

    arb_state_e  state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        favour_mem_q, favour_mem_d;
    logic        squash_q, squash_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        mem_valid_q, mem_valid_d;
    logic        err_q, err_d;

    logic        if_eligible;
    logic        grant_mem;
    logic        grant_if;
    logic        timeout;
    logic        squash_now;

    // A fetch presented together with a redirect is stale and never granted.
    assign if_eligible = i_IF_req & ~i_IF_flush;
    // MEM wins if IF is absent, under fixed data priority, or when it is MEM's
    // turn in round-robin.
    assign grant_mem   = i_MEM_req & (~if_eligible | DATA_PRIORITY | favour_mem_q);
    assign grant_if    = if_eligible & ~grant_mem;
    assign timeout     = ~i_mem_ready & (wait_cnt_q == LAST_WAIT);
    // A redirect in the completion cycle still squashes the fetch.
    assign squash_now  = squash_q | i_IF_flush;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        favour_mem_d = favour_mem_q;
        squash_d     = squash_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        if_rdata_d   = if_rdata_q;
        if_valid_d   = 1'b0;
        mem_rdata_d  = mem_rdata_q;
        mem_valid_d  = 1'b0;
        err_d        = err_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_mem) begin
                    state_d      = ST_DBUSY;
                    wait_cnt_d   = '0;
                    favour_mem_d = 1'b0;
                    mem_req_d    = 1'b1;
                    mem_we_d     = i_MEM_we;
                    mem_addr_d   = i_MEM_addr;
                    mem_wdata_d  = i_MEM_wdata;
                    mem_be_d     = i_MEM_be;
                end else if (grant_if) begin
                    state_d      = ST_IBUSY;
                    wait_cnt_d   = '0;
                    favour_mem_d = 1'b1;
                    squash_d     = 1'b0;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = i_IF_addr;
                    mem_wdata_d  = '0;
                    mem_be_d     = IF_FETCH_BE;
                end
            end

            ST_IBUSY, ST_DBUSY: begin
                wait_cnt_d = wait_cnt_q + 4'd1;
                if (state_q == ST_IBUSY) begin
                    squash_d = squash_now;
                end
                if (i_mem_ready || timeout) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                    mem_req_d  = 1'b0;
                    if (timeout) begin
                        err_d = 1'b1;
                    end
                    if (state_q == ST_IBUSY) begin
                        // A squashed fetch still finishes on the port but is
                        // invisible to the pipeline.
                        if (!squash_now) begin
                            if_valid_d = 1'b1;
                            if_rdata_d = timeout ? TIMEOUT_RDATA : i_mem_rdata;
                        end
                    end else begin
                        mem_valid_d = 1'b1;
                        if (timeout) begin
                            mem_rdata_d = TIMEOUT_RDATA;
                        end else if (!mem_we_q) begin
                            mem_rdata_d = i_mem_rdata;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= '0;
            favour_mem_q <= 1'b0;
            squash_q     <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            if_rdata_q   <= '0;
            if_valid_q   <= 1'b0;
            mem_rdata_q  <= '0;
            mem_valid_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            favour_mem_q <= favour_mem_d;
            squash_q     <= squash_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            if_rdata_q   <= if_rdata_d;
            if_valid_q   <= if_valid_d;
            mem_rdata_q  <= mem_rdata_d;
            mem_valid_q  <= mem_valid_d;
            err_q        <= err_d;
        end
    end

    assign o_IF_rdata  = if_rdata_q;
    assign o_IF_valid  = if_valid_q;
    assign o_IF_stall  = i_IF_req & ~if_valid_q;
    assign o_MEM_rdata = mem_rdata_q;
    assign o_MEM_valid = mem_valid_q;
    assign o_MEM_stall = i_MEM_req & ~mem_valid_q;
    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_be    = mem_be_q;
    assign o_err       = err_q;

endmodule
